// File: rtl/sr_decode_pkg.sv
// sr_decode_pkg: shared types and RV32I opcode constants.
// Optional SR_DECODE_ILLEGAL_EN enables the illegal-opcode helper use.
package sr_decode_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL1 = 2'd1,
    ST_FULL2 = 2'd2
  } skid_st_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  function automatic logic is_rv32i_op(logic [6:0] op);
    case (op)
      OP_LOAD, OP_FENCE, OP_IMM, OP_AUIPC,
      OP_STORE, OP_REG, OP_LUI, OP_BRANCH,
      OP_JALR, OP_JAL, OP_SYSTEM:
        is_rv32i_op = 1'b1;
      default:
        is_rv32i_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sr_decode_if.sv
// sr_decode_if: fetch-side and execute-side handshake bundle.
// Carries the illegal flag only when SR_DECODE_ILLEGAL_EN is defined.
interface sr_decode_if
  import sr_decode_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      cmdOp;
  logic [4:0]      rd;
  logic [2:0]      cmdF3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      cmdF7;
  logic [XLEN-1:0] imm;
  imm_type_t       immType;
`ifdef SR_DECODE_ILLEGAL_EN
  logic            illegal;
`endif

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid,
    output cmdOp, rd, cmdF3, rs1, rs2, cmdF7,
`ifdef SR_DECODE_ILLEGAL_EN
    output illegal,
`endif
    output imm, immType
  );

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid,
    input  cmdOp, rd, cmdF3, rs1, rs2, cmdF7,
`ifdef SR_DECODE_ILLEGAL_EN
    input  illegal,
`endif
    input  imm, immType
  );
endinterface

// File: rtl/sr_decode_stage_imm_gen.sv
// sr_imm_gen: picks the opcode's immediate format and
// sign-extends it from instr[31] to XLEN.
module sr_imm_gen
  import sr_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_type_t       type_o
);
  logic [31:0] imm32;

  // format select; NONE leaves the immediate at zero
  always_comb begin
    imm32  = '0;
    type_o = IMM_NONE;
    unique case (instr_i[6:0])
      OP_LOAD, OP_IMM, OP_JALR: begin
        type_o = IMM_I;
        imm32  = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OP_STORE: begin
        type_o = IMM_S;
        imm32  = {{20{instr_i[31]}}, instr_i[31:25],
                  instr_i[11:7]};
      end
      OP_BRANCH: begin
        type_o = IMM_B;
        imm32  = {{19{instr_i[31]}}, instr_i[31],
                  instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        type_o = IMM_U;
        imm32  = {instr_i[31:12], 12'b0};
      end
      OP_JAL: begin
        type_o = IMM_J;
        imm32  = {{11{instr_i[31]}}, instr_i[31],
                  instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};
      end
      default: begin
        type_o = IMM_NONE;
        imm32  = '0;
      end
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/sr_decode_stage.sv
// sr_decode_stage: registered RV32I decode behind a 2-entry skid.
// Define SR_DECODE_ILLEGAL_EN to add the registered illegal flag.
module sr_decode_stage
  import sr_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  sr_decode_if.slave  bus
);
  skid_st_t        st_q;
  logic            out_valid_q;
  logic            in_ready_q;

  logic [31:0]     m_instr_q, s_instr_q;
  logic [XLEN-1:0] m_imm_q, s_imm_q;
  imm_type_t       m_type_q, s_type_q;

  logic [XLEN-1:0] imm_d;
  imm_type_t       type_d;

  logic accept, emit;
  logic m_new, m_from_s, s_load;

  sr_imm_gen #(.XLEN(XLEN)) u_imm (
    .instr_i (bus.instr),
    .imm_o   (imm_d),
    .type_o  (type_d)
  );

  assign accept   = bus.in_valid && in_ready_q;
  assign emit     = out_valid_q && bus.out_ready;
  assign m_new    = accept && (!out_valid_q || emit);
  assign m_from_s = (st_q == ST_FULL2) && emit;
  assign s_load   = accept && out_valid_q && !emit;

  // handshake FSM with registered out_valid / in_ready
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      st_q        <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (st_q)
        ST_EMPTY: begin
          if (accept) begin
            st_q        <= ST_FULL1;
            out_valid_q <= 1'b1;
          end
        end
        ST_FULL1: begin
          if (accept && !emit) begin
            st_q       <= ST_FULL2;
            in_ready_q <= 1'b0;
          end else if (emit && !accept) begin
            st_q        <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_FULL2: begin
          if (emit) begin
            st_q       <= ST_FULL1;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          st_q        <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // M/S data; flush only drops valid bits, data is kept
  always_ff @(posedge clk) begin
    if (rst) begin
      m_instr_q <= '0;
      m_imm_q   <= '0;
      m_type_q  <= IMM_NONE;
      s_instr_q <= '0;
      s_imm_q   <= '0;
      s_type_q  <= IMM_NONE;
    end else if (!flush) begin
      if (m_new) begin
        m_instr_q <= bus.instr;
        m_imm_q   <= imm_d;
        m_type_q  <= type_d;
      end else if (m_from_s) begin
        m_instr_q <= s_instr_q;
        m_imm_q   <= s_imm_q;
        m_type_q  <= s_type_q;
      end
      if (s_load) begin
        s_instr_q <= bus.instr;
        s_imm_q   <= imm_d;
        s_type_q  <= type_d;
      end
    end
  end

`ifdef SR_DECODE_ILLEGAL_EN
  logic ill_d, m_ill_q, s_ill_q;

  assign ill_d = (bus.instr[1:0] != 2'b11) ||
                 !is_rv32i_op(bus.instr[6:0]);

  // illegal flag travels with its entry
  always_ff @(posedge clk) begin
    if (rst) begin
      m_ill_q <= 1'b0;
      s_ill_q <= 1'b0;
    end else if (!flush) begin
      if (m_new)
        m_ill_q <= ill_d;
      else if (m_from_s)
        m_ill_q <= s_ill_q;
      if (s_load)
        s_ill_q <= ill_d;
    end
  end

  assign bus.illegal = m_ill_q;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cmdOp     = m_instr_q[6:0];
  assign bus.rd        = m_instr_q[11:7];
  assign bus.cmdF3     = m_instr_q[14:12];
  assign bus.rs1       = m_instr_q[19:15];
  assign bus.rs2       = m_instr_q[24:20];
  assign bus.cmdF7     = m_instr_q[31:25];
  assign bus.imm       = m_imm_q;
  assign bus.immType   = m_type_q;

endmodule
